// File: rtl/mem_program_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, prefetches ROM words into a small FIFO.
// Optional MEM_FETCH_STATS_EN adds the fetch_count pop counter port.
module mem_program_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef MEM_FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [31:0]      PC_RST  = RESET_PC & ~32'd3;

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      mem_pc_q   [FIFO_DEPTH];
    logic [31:0]      mem_word_q [FIFO_DEPTH];
    logic             pop;
    logic             push;

    assign pop  = (count_q != '0) & instr_ready;
    assign push = !redirect_valid & ((count_q < DEPTH) | pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            // Flush: the head is discarded even if the consumer is ready.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            pc_d     = redirect_pc & ~32'd3;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_RST;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; reads are gated by count_q.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc_q[wr_ptr_q]   <= pc_q;
            mem_word_q[wr_ptr_q] <= rom_data;
        end
    end

    assign rom_addr    = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? mem_word_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q] : 32'h0;

`ifdef MEM_FETCH_STATS_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else if (pop && !redirect_valid) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_mem_program_fetch_ctrl.sv
// Bench for mem_program_fetch_ctrl: directed scenarios plus randomized run against a queue model.
// Define MEM_FETCH_STATS_EN to also exercise the fetch_count port.
module tb_mem_program_fetch_ctrl;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef MEM_FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc  = RPC;
    logic [31:0] mstat = 32'h0;

    always #5 clk = ~clk;

    // ROM content: word n holds n.
    assign rom_data = rom_addr >> 2;

    mem_program_fetch_ctrl #(
        .RESET_PC  (RPC),
        .FIFO_DEPTH(D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
`ifdef MEM_FETCH_STATS_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    // Apply inputs for one cycle, advance the model, return at the next falling edge.
    task automatic step(input logic r, input logic rv,
                        input logic [31:0] rp, input logic rdy);
        ent_t e;
        bit   was_full;
        bit   do_pop;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        instr_ready    = rdy;
        if (r) begin
            mq.delete();
            mpc   = RPC & ~32'd3;
            mstat = 32'h0;
        end else if (rv) begin
            mq.delete();
            mpc = rp & ~32'd3;
        end else begin
            was_full = (mq.size() >= D);
            do_pop   = (mq.size() > 0) && rdy;
            if (do_pop) begin
                void'(mq.pop_front());
                mstat = mstat + 32'd1;
            end
            if (!was_full || do_pop) begin
                e.pc   = mpc;
                e.word = mpc >> 2;
                mq.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h44, 1'b1);
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%0b exp=0", instr_valid);
        end
        checks++;
        if (instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=0", instr);
        end
        checks++;
        if (instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=0", instr_pc);
        end
        checks++;
        if (rom_addr !== RPC) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=%h", rom_addr, RPC);
        end
    endtask

    task automatic test_stream();
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, 32'(4 * k), 32'(k)}) begin
                failures++;
                $display("FAIL stream[%0d] got v=%0b pc=%h i=%h exp v=1 pc=%h i=%h",
                         k, instr_valid, instr_pc, instr, 32'(4 * k), 32'(k));
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({instr_valid, instr_pc, rom_addr} !== {1'b1, 32'h0, 32'h8}) begin
            failures++;
            $display("FAIL stall_hold got v=%0b pc=%h addr=%h exp v=1 pc=0 addr=8",
                     instr_valid, instr_pc, rom_addr);
        end
        for (int k = 1; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({instr_valid, instr_pc} !== {1'b1, 32'(4 * k)}) begin
                failures++;
                $display("FAIL stall_drain[%0d] got v=%0b pc=%h exp v=1 pc=%h",
                         k, instr_valid, instr_pc, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect_full();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0013, 1'b1);
        checks++;
        if ({instr_valid, instr, rom_addr} !== {1'b0, 32'h0, 32'h10}) begin
            failures++;
            $display("FAIL redir_flush got v=%0b i=%h addr=%h exp v=0 i=0 addr=10",
                     instr_valid, instr, rom_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h10, 32'h4}) begin
            failures++;
            $display("FAIL redir_target got v=%0b pc=%h i=%h exp v=1 pc=10 i=4",
                     instr_valid, instr_pc, instr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc[k], exp_pc[k] >> 2}) begin
                failures++;
                $display("FAIL wrap[%0d] got v=%0b pc=%h i=%h exp pc=%h",
                         k, instr_valid, instr_pc, instr, exp_pc[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        checks++;
        if ({instr_valid, instr, instr_pc, rom_addr} !== {1'b0, 32'h0, 32'h0, RPC}) begin
            failures++;
            $display("FAIL rst_mid got v=%0b i=%h pc=%h addr=%h exp v=0 i=0 pc=0 addr=%h",
                     instr_valid, instr, instr_pc, rom_addr, RPC);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({instr_valid, instr_pc, rom_addr} !== {1'b1, RPC, RPC + 32'd4}) begin
            failures++;
            $display("FAIL rst_resume got v=%0b pc=%h addr=%h exp v=1 pc=%h",
                     instr_valid, instr_pc, rom_addr, RPC);
        end
    endtask

    task automatic test_random();
        logic        r, rv, rdy, ev;
        logic [31:0] rp, ei, ep;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : $urandom;
            step(r, rv, rp, rdy);
            ev = (mq.size() != 0);
            ei = ev ? mq[0].word : 32'h0;
            ep = ev ? mq[0].pc : 32'h0;
            checks++;
            if ({instr_valid, instr, instr_pc, rom_addr} !== {ev, ei, ep, mpc}) begin
                failures++;
                $display("FAIL rand[%0d] got v=%0b i=%h pc=%h addr=%h exp v=%0b i=%h pc=%h addr=%h",
                         n, instr_valid, instr, instr_pc, rom_addr, ev, ei, ep, mpc);
            end
`ifdef MEM_FETCH_STATS_EN
            checks++;
            if (fetch_count !== mstat) begin
                failures++;
                $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, fetch_count, mstat);
            end
`endif
        end
    endtask

`ifdef MEM_FETCH_STATS_EN
    task automatic test_stats();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        checks++;
        if (fetch_count !== 32'd10) begin
            failures++;
            $display("FAIL stats_count got=%0d exp=10", fetch_count);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
`ifdef MEM_FETCH_STATS_EN
        test_stats();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
